// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the 8-bit VRAM port between the Nick video fetcher and the Z80.
// Video owns two fixed fetch slots per 16-tick character period and always wins them.
// The CPU is held in wait until exactly one access has been made in a free slot.
// Ports:
//   clock, reset    system clock; asynchronous active-low reset
//   cepix           pixel clock enable, one slot per tick
//   hs              slot phase within the character period
//   vfetch          video fetch window active; when low every slot is free
//   va / vd         video address / video read data (= ram_q)
//   cpu_req/we/a/d  CPU request level, direction, address, write data
//   cpu_q           registered CPU read data
//   cpu_wait        CPU wait, high while a request is outstanding
//   ram_a/d/we/q    VRAM address, write data, write strobe, read data
module vram_arbiter #(
   parameter logic [3:0] VSLOT1 = 4'd4,
   parameter logic [3:0] VSLOT2 = 4'd9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cepix,
   input  logic [3:0]  hs,
   input  logic        vfetch,
   input  logic [15:0] va,
   output logic [7:0]  vd,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_wait,
   output logic [15:0] ram_a,
   output logic [7:0]  ram_d,
   output logic        ram_we,
   input  logic [7:0]  ram_q
);
   typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
   state_t state, state_nx;
   logic        lwe;
   logic [15:0] la;
   logic [7:0]  ld;
   logic        vslot, grant, latch;
   assign vslot = vfetch && (hs == VSLOT1 || hs == VSLOT2);
   always_comb begin
      state_nx = state;
      grant = 1'b0;
      latch = 1'b0;
      if (cepix)
         case (state)
            IDLE: if (cpu_req) begin
               latch = 1'b1;
               state_nx = PEND;
            end
            PEND: if (!cpu_req) state_nx = IDLE;
               else if (!vslot) begin
                  grant = 1'b1;
                  state_nx = DONE;
               end
            DONE: if (!cpu_req) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cpu_q <= 8'h00;
         lwe <= 1'b0;
         la <= 16'h0000;
         ld <= 8'h00;
      end else begin
         state <= state_nx;
         if (latch) begin
            lwe <= cpu_we;
            la <= cpu_a;
            ld <= cpu_d;
         end
         if (grant && !lwe) cpu_q <= ram_q;
      end
   // DONE drops wait so the CPU sees completion; the first request tick is always a wait state.
   assign cpu_wait = cpu_req && state != DONE;
   assign ram_a = (state == PEND && !vslot) ? la : va;
   assign ram_d = ld;
   assign ram_we = grant && lwe;
   assign vd = ram_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural 64K VRAM.
module tb_vram_arbiter;
   typedef struct {
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  q;
      int          lat;
   } exp_t;
   logic clock, reset, cepix, vfetch, cpu_req, cpu_we, cpu_wait, ram_we;
   logic [3:0]  hs;
   logic [15:0] va, cpu_a, ram_a;
   logic [7:0]  vd, cpu_d, cpu_q, ram_d, ram_q;
   logic [7:0]  mem [0:65535];
   logic [7:0]  wr [logic [15:0]];
   exp_t sb[$];
   int vectors = 0, miscompares = 0, lat = 0, wcount = 0;
   bit done = 0;
   vram_arbiter dut (
      .clock(clock), .reset(reset), .cepix(cepix), .hs(hs), .vfetch(vfetch),
      .va(va), .vd(vd), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a),
      .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_wait(cpu_wait), .ram_a(ram_a),
      .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) begin
      cepix <= ~cepix;
      if (cepix) hs <= hs + 4'd1;
   end
   always @(posedge clock) if (ram_we && cepix) mem[ram_a] <= ram_d;
   assign ram_q = mem[ram_a];
   assign va = {12'h4A0, hs};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] expq(input logic [15:0] a);
      return wr.exists(a) ? wr[a] : pat(a);
   endfunction
   // Ticks with wait high: the request tick, each video slot after it, then the grant tick.
   function automatic int model_lat(input logic [3:0] h, input logic vf);
      int l = 1;
      logic [3:0] t = h + 4'd1;
      while (vf && (t == 4'd4 || t == 4'd9)) begin
         l++;
         t++;
      end
      return l + 1;
   endfunction
   always @(negedge clock) begin
      if (!cpu_req) done = 0;
      if (reset && cepix) begin
         if (ram_we) begin
            wcount++;
            if (sb.size() > 0) begin
               chk("wr_a", ram_a, sb[0].a);
               chk("wr_d", ram_d, sb[0].d);
            end else chk("wr_unexp", 1, 0);
         end
         if (cpu_req && cpu_wait) lat++;
         if (cpu_req && cpu_wait && vfetch && (hs == 4'd4 || hs == 4'd9)) chk("vslot_a", ram_a, va);
      end
      if (reset && cpu_req && !cpu_wait && !done) begin
         done = 1;
         if (sb.size() == 0) chk("done_unexp", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("lat", lat, e.lat);
            chk("we_cnt", wcount, {31'd0, e.we});
            if (!e.we) chk("rd_q", cpu_q, e.q);
         end
      end
   end
   task automatic wait_tick(input logic [3:0] h);
      int n = 0;
      do begin
         @(posedge clock);
         #2;
         n++;
      end while (!(cepix && hs == h) && n < 100);
      if (n >= 100) chk("tick_to", 1, 0);
   endtask
   task automatic finish_access(input logic we);
      int n = 0;
      do begin
         @(posedge clock);
         #2;
         n++;
      end while (cpu_wait && n < 60);
      if (cpu_wait) begin
         chk("wait_to", 1, 0);
         sb.delete();
      end
      repeat (6) @(posedge clock);
      #2 cpu_req = 1'b0;
      repeat (4) @(posedge clock);
      #2 chk("we_total", wcount, {31'd0, we});
   endtask
   task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input logic [3:0] h, input logic vf);
      exp_t e;
      wait_tick(h);
      vfetch = vf;
      cpu_we = we;
      cpu_a = a;
      cpu_d = d;
      e.we = we;
      e.a = a;
      e.d = d;
      e.q = we ? 8'h00 : expq(a);
      e.lat = model_lat(h, vf);
      if (we) wr[a] = d;
      sb.push_back(e);
      lat = 0;
      wcount = 0;
      cpu_req = 1'b1;
      finish_access(we);
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      mem[16'h1234] = 8'h5A;
      wr[16'h1234] = 8'h5A;
      cepix = 1'b0;
      hs = 4'd0;
      reset = 1'b0;
      vfetch = 1'b1;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_a = 16'h0000;
      cpu_d = 8'h00;
      #12;
      chk("rst_wait", cpu_wait, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_q", cpu_q, 0);
      chk("rst_a", ram_a, va);
      chk("vd", vd, ram_q);
      cpu_req = 1'b1;
      #1 chk("rst_wait_req", cpu_wait, 1);
      cpu_req = 1'b0;
      #5 reset = 1'b1;
      access(1'b0, 16'h1234, 8'h00, 4'd1, 1'b1);
      access(1'b0, 16'h3456, 8'h00, 4'd3, 1'b1);
      access(1'b1, 16'hBFFF, 8'hC3, 4'd1, 1'b1);
      access(1'b0, 16'hBFFF, 8'h00, 4'd8, 1'b1);
      access(1'b0, 16'h7001, 8'h00, 4'd3, 1'b0);
      access(1'b0, 16'h00F0, 8'h00, 4'd15, 1'b1);
      // abort: request latched at hs=3, dropped before the hs=4 tick
      wait_tick(4'd3);
      vfetch = 1'b1;
      cpu_we = 1'b1;
      cpu_a = 16'h0F0F;
      cpu_d = 8'h99;
      lat = 0;
      wcount = 0;
      cpu_req = 1'b1;
      @(posedge clock);
      #2 cpu_req = 1'b0;
      repeat (6) @(posedge clock);
      #2;
      chk("abort_we", wcount, 0);
      chk("abort_sb", sb.size(), 0);
      chk("abort_wait", cpu_wait, 0);
      access(1'b0, 16'h0F0F, 8'h00, 4'd6, 1'b1);
      // reset while pending
      access(1'b0, 16'h1234, 8'h00, 4'd1, 1'b1);
      wait_tick(4'd3);
      vfetch = 1'b1;
      cpu_we = 1'b0;
      cpu_a = 16'h2222;
      lat = 0;
      wcount = 0;
      cpu_req = 1'b1;
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rstp_we", ram_we, 0);
      chk("rstp_q", cpu_q, 0);
      chk("rstp_wait", cpu_wait, 1);
      chk("rstp_a", ram_a, va);
      #1 reset = 1'b1;
      begin
         exp_t e;
         e.we = 1'b0;
         e.a = 16'h2222;
         e.d = 8'h00;
         e.q = expq(16'h2222);
         e.lat = model_lat(4'd4, 1'b1);
         lat = 0;
         wcount = 0;
         sb.push_back(e);
      end
      finish_access(1'b0);
      for (int i = 0; i < 12; i++)
         access(1'($urandom_range(0, 1)), {12'hC00, 4'($urandom_range(0, 15))}, 8'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
